// File: rtl/conv_via_tiling_mul_pkg.sv
// Shared widths and pipeline stage record for the tiling-convolution multiplier arbiter.
package conv_via_tiling_mul_pkg;
  localparam int unsigned MUL_A_W  = 32;
  localparam int unsigned MUL_B_W  = 36;
  localparam int unsigned MUL_P_W  = 68;
  // Id field sized for the widest configuration (8 requesters).
  localparam int unsigned MAX_ID_W = 3;

  typedef struct packed {
    logic                v;
    logic [MAX_ID_W-1:0] id;
    logic [MUL_P_W-1:0]  p;
  } mul_stage_t;
endpackage

// File: rtl/conv_via_tiling_mul_32ns_36ns_68_1_1.sv
// Combinational unsigned multiplier core shared by the tiling datapath.
module conv_via_tiling_mul_32ns_36ns_68_1_1 #(
  parameter int unsigned din0_WIDTH = 32,
  parameter int unsigned din1_WIDTH = 36,
  parameter int unsigned dout_WIDTH = 68
) (
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic [dout_WIDTH-1:0] dout
);
  assign dout = dout_WIDTH'(din0) * dout_WIDTH'(din1);
endmodule

// File: rtl/conv_via_tiling_rr_arbiter.sv
// Round-robin arbiter: search starts at ptr, ptr moves past the grantee on acceptance.
module conv_via_tiling_rr_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             en,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] w_idx;
  logic             w_any;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    w_any     = 1'b0;
    w_idx     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_idx = IDX_W'((32'(r_ptr) + k) % N);
      if (!w_any && req[w_idx]) begin
        grant[w_idx] = 1'b1;
        grant_idx    = w_idx;
        w_any        = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (en && w_any) begin
      r_ptr <= (32'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
    end
  end
endmodule

// File: rtl/conv_via_tiling_mul_arbiter.sv
// Shares one 32x36->68 multiplier among N_REQ valid/ready requesters through a
// globally stalled pipeline with a single tagged, backpressured response port.
module conv_via_tiling_mul_arbiter
  import conv_via_tiling_mul_pkg::*;
#(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned PIPE_STAGES = 2,
  parameter int unsigned ID_W        = $clog2(N_REQ)
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst_n,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*MUL_A_W-1:0] req_a,
  input  logic [N_REQ*MUL_B_W-1:0] req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [MUL_P_W-1:0]       rsp_p,
  output logic [2:0]               inflight,
  output logic                     idle
);
  localparam int unsigned LAST = PIPE_STAGES - 1;

  logic                r_s0_v;
  logic [ID_W-1:0]     r_s0_id;
  logic [MUL_A_W-1:0]  r_s0_a;
  logic [MUL_B_W-1:0]  r_s0_b;
  mul_stage_t          r_pstg [1:LAST];

  logic                w_adv;
  logic                w_any;
  logic [N_REQ-1:0]    w_grant;
  logic [ID_W-1:0]     w_grant_idx;
  logic [MUL_A_W-1:0]  w_a_sel;
  logic [MUL_B_W-1:0]  w_b_sel;
  logic [MUL_P_W-1:0]  w_prod;
  logic [2:0]          w_inflight;
  logic                w_unused_id;

  // Single global stall: every stage, bubbles included, shifts only on w_adv.
  assign w_adv = !r_pstg[LAST].v || rsp_ready;
  assign w_any = |w_grant;

  conv_via_tiling_rr_arbiter #(
    .N     (N_REQ),
    .IDX_W (ID_W)
  ) u_arb (
    .clk       (ap_clk),
    .rst_n     (ap_rst_n),
    .req       (req_valid),
    .en        (w_adv),
    .grant     (w_grant),
    .grant_idx (w_grant_idx)
  );

  assign req_ready = w_adv ? w_grant : '0;
  assign w_a_sel   = req_a[w_grant_idx*MUL_A_W +: MUL_A_W];
  assign w_b_sel   = req_b[w_grant_idx*MUL_B_W +: MUL_B_W];

  conv_via_tiling_mul_32ns_36ns_68_1_1 #(
    .din0_WIDTH (MUL_A_W),
    .din1_WIDTH (MUL_B_W),
    .dout_WIDTH (MUL_P_W)
  ) u_mul (
    .din0 (r_s0_a),
    .din1 (r_s0_b),
    .dout (w_prod)
  );

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_s0_v  <= 1'b0;
      r_s0_id <= '0;
      r_s0_a  <= '0;
      r_s0_b  <= '0;
      for (int unsigned s = 1; s <= LAST; s++) r_pstg[s] <= '0;
    end else if (w_adv) begin
      r_s0_v    <= w_any;
      r_s0_id   <= w_grant_idx;
      r_s0_a    <= w_a_sel;
      r_s0_b    <= w_b_sel;
      r_pstg[1] <= '{v: r_s0_v, id: MAX_ID_W'(r_s0_id), p: w_prod};
      for (int unsigned s = 2; s <= LAST; s++) r_pstg[s] <= r_pstg[s-1];
    end
  end

  always_comb begin
    w_inflight = 3'(r_s0_v);
    for (int unsigned s = 1; s <= LAST; s++) w_inflight = w_inflight + 3'(r_pstg[s].v);
  end

  assign rsp_valid = r_pstg[LAST].v;
  assign rsp_id    = r_pstg[LAST].id[ID_W-1:0];
  assign rsp_p     = r_pstg[LAST].p;
  assign inflight  = w_inflight;
  assign idle      = (w_inflight == '0) && (req_valid == '0);

  // Upper id bits only carry data in the widest configuration.
  assign w_unused_id = ^r_pstg[LAST].id;
endmodule

// File: tb/tb_conv_via_tiling_mul_arbiter.sv
// Self-checking bench: directed vectors plus randomized traffic against a queue-based model.
module tb_conv_via_tiling_mul_arbiter;
  localparam int N   = 4;
  localparam int PS  = 2;
  localparam int IDW = 2;

  logic              ap_clk = 1'b0;
  logic              ap_rst_n = 1'b1;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*32-1:0]   req_a;
  logic [N*36-1:0]   req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [67:0]       rsp_p;
  logic [2:0]        inflight;
  logic              idle;

  logic [31:0] a_arr [N];
  logic [35:0] b_arr [N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_a[i*32 +: 32] = a_arr[i];
      req_b[i*36 +: 36] = b_arr[i];
    end
  end

  always #5 ap_clk = ~ap_clk;

  conv_via_tiling_mul_arbiter #(
    .N_REQ       (N),
    .PIPE_STAGES (PS)
  ) dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_p     (rsp_p),
    .inflight  (inflight),
    .idle      (idle)
  );

  int n_pass  = 0;
  int n_total = 0;

  function automatic void chk(string nm, logic [67:0] act, logic [67:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endfunction

  // Reference model: in-order queue of accepted requests, each with the number
  // of pipeline advances it has seen; the head is visible once it reaches the last stage.
  typedef struct {
    int          id;
    logic [67:0] p;
    int          stg;
  } ent_t;
  ent_t q[$];
  int   m_ptr = 0;
  int   m_g;
  bit   m_rv;
  bit   m_adv;

  always @(negedge ap_clk) begin
    if (!ap_rst_n) begin
      q.delete();
      m_ptr = 0;
    end else begin
      m_rv  = (q.size() > 0) && (q[0].stg == PS - 1);
      m_adv = !m_rv || rsp_ready;
      chk("mon.inflight", 68'(inflight), 68'(q.size()));
      chk("mon.idle", 68'(idle), (q.size() == 0 && req_valid == '0) ? 68'd1 : 68'd0);
      chk("mon.rsp_valid", 68'(rsp_valid), m_rv ? 68'd1 : 68'd0);
      if (m_rv) begin
        chk("mon.rsp_id", 68'(rsp_id), 68'(q[0].id));
        chk("mon.rsp_p", rsp_p, q[0].p);
      end
      m_g = -1;
      if (m_adv)
        for (int k = 0; k < N; k++)
          if (m_g < 0 && req_valid[(m_ptr + k) % N]) m_g = (m_ptr + k) % N;
      chk("mon.req_ready", 68'(req_ready), (m_g >= 0) ? (68'd1 << m_g) : 68'd0);
      if (m_rv && rsp_ready) void'(q.pop_front());
      if (m_adv) foreach (q[i]) q[i].stg = q[i].stg + 1;
      if (m_g >= 0) begin
        q.push_back('{m_g, 68'(a_arr[m_g]) * 68'(b_arr[m_g]), 0});
        m_ptr = (m_g + 1) % N;
      end
    end
  end

  task automatic sync();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic new_data(int i);
    a_arr[i] = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
    b_arr[i] = ($urandom_range(0, 7) == 0) ? 36'hF_FFFF_FFFF : {4'($urandom), 32'($urandom)};
  endtask

  task automatic do_reset();
    ap_rst_n  = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge ap_clk);
    #1 ap_rst_n = 1'b1;
  endtask

  // One cycle of requester traffic; a requester holds its operands until accepted.
  task automatic tick(int p_valid, int p_rdy);
    logic [N-1:0] acc;
    @(negedge ap_clk);
    acc = req_valid & req_ready;
    sync();
    for (int i = 0; i < N; i++)
      if (acc[i] || !req_valid[i]) begin
        req_valid[i] = ($urandom_range(0, 99) < p_valid);
        new_data(i);
      end
    rsp_ready = ($urandom_range(0, 99) < p_rdy);
  endtask

  task automatic drain(string nm);
    int n;
    n         = 0;
    req_valid = '0;
    rsp_ready = 1'b1;
    @(negedge ap_clk);
    while (!idle && n < 20) begin
      @(negedge ap_clk);
      n++;
    end
    chk({nm, ".idle"}, 68'(idle), 68'd1);
    chk({nm, ".sb_empty"}, 68'(q.size()), 68'd0);
    sync();
  endtask

  // Single isolated request on an empty pipe; checks latency, product and idle after consume.
  task automatic single(string nm, int id, logic [31:0] a, logic [35:0] b, logic [67:0] p);
    rsp_ready     = 1'b1;
    req_valid     = '0;
    a_arr[id]     = a;
    b_arr[id]     = b;
    req_valid[id] = 1'b1;
    @(negedge ap_clk);
    chk({nm, ".req_ready"}, 68'(req_ready), 68'd1 << id);
    sync();
    req_valid = '0;
    @(negedge ap_clk);
    chk({nm, ".early_valid"}, 68'(rsp_valid), 68'd0);
    @(negedge ap_clk);
    chk({nm, ".rsp_valid"}, 68'(rsp_valid), 68'd1);
    chk({nm, ".rsp_id"}, 68'(rsp_id), 68'(id));
    chk({nm, ".rsp_p"}, rsp_p, p);
    @(negedge ap_clk);
    chk({nm, ".idle"}, 68'(idle), 68'd1);
    sync();
  endtask

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [35:0] b;
    logic [67:0] p;
  } vec_t;
  vec_t vt [7];

  logic [N-1:0]   acc_f;
  logic [IDW-1:0] h_id;
  logic [67:0]    h_p;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    vt[0] = '{2, 32'd3, 36'd5, 68'd15};
    vt[1] = '{0, 32'hFFFF_FFFF, 36'hF_FFFF_FFFF, 68'hF_FFFF_FFEF_0000_0001};
    vt[2] = '{1, 32'd0, 36'h9_ABCD_1234, 68'd0};
    vt[3] = '{3, 32'd1, 36'hF_FFFF_FFFF, 68'hF_FFFF_FFFF};
    vt[4] = '{2, 32'h8000_0000, 36'd2, 68'h1_0000_0000};
    vt[5] = '{1, 32'hFFFF_FFFF, 36'h1_0000_0000, 68'hFFFF_FFFF_0000_0000};
    vt[6] = '{0, 32'd12345, 36'd1000, 68'd12345000};
    for (int i = 0; i < N; i++) begin
      a_arr[i] = '0;
      b_arr[i] = '0;
    end
    req_valid = '0;
    rsp_ready = 1'b0;

    #1 ap_rst_n = 1'b0;
    #2;
    chk("rst.rsp_valid", 68'(rsp_valid), 68'd0);
    chk("rst.rsp_id", 68'(rsp_id), 68'd0);
    chk("rst.rsp_p", rsp_p, 68'd0);
    chk("rst.req_ready", 68'(req_ready), 68'd0);
    chk("rst.inflight", 68'(inflight), 68'd0);
    chk("rst.idle", 68'(idle), 68'd1);
    repeat (2) @(posedge ap_clk);
    #1 ap_rst_n = 1'b1;

    foreach (vt[i]) single($sformatf("vec%0d", i), vt[i].id, vt[i].a, vt[i].b, vt[i].p);

    // All requesters valid after reset: strict 0,1,2,3 rotation and matching response order.
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) new_data(i);
    req_valid = '1;
    for (int k = 0; k < 10; k++) begin
      if (k == 8) req_valid = '0;
      @(negedge ap_clk);
      acc_f = req_valid & req_ready;
      if (k < 8) chk($sformatf("fair.grant%0d", k), 68'(req_ready), 68'd1 << (k % N));
      if (k >= 2) begin
        chk($sformatf("fair.rsp_valid%0d", k), 68'(rsp_valid), 68'd1);
        chk($sformatf("fair.rsp_id%0d", k), 68'(rsp_id), 68'((k - 2) % N));
      end
      sync();
      for (int i = 0; i < N; i++) if (acc_f[i]) new_data(i);
    end
    drain("fair");

    // Pointer moves past the last grantee: 1, then 3 (not 1), then 1.
    do_reset();
    rsp_ready = 1'b1;
    new_data(1);
    new_data(3);
    req_valid = 4'b0010;
    @(negedge ap_clk);
    chk("ptr.grant_1", 68'(req_ready), 68'b0010);
    sync();
    new_data(1);
    req_valid = 4'b1010;
    @(negedge ap_clk);
    chk("ptr.grant_3", 68'(req_ready), 68'b1000);
    sync();
    req_valid = 4'b0010;
    @(negedge ap_clk);
    chk("ptr.grant_1_again", 68'(req_ready), 68'b0010);
    sync();
    drain("ptr");

    // Back-to-back stream, then three stalled cycles with the pipe full.
    for (int i = 0; i < N; i++) new_data(i);
    req_valid = '1;
    rsp_ready = 1'b1;
    repeat (4) tick(100, 100);
    rsp_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge ap_clk);
      if (s == 0) begin
        h_id = rsp_id;
        h_p  = rsp_p;
      end else begin
        chk($sformatf("stall.id_hold%0d", s), 68'(rsp_id), 68'(h_id));
        chk($sformatf("stall.p_hold%0d", s), rsp_p, h_p);
      end
      chk($sformatf("stall.req_ready%0d", s), 68'(req_ready), 68'd0);
      chk($sformatf("stall.rsp_valid%0d", s), 68'(rsp_valid), 68'd1);
      chk($sformatf("stall.inflight%0d", s), 68'(inflight), 68'd2);
      sync();
    end
    rsp_ready = 1'b1;
    @(negedge ap_clk);
    chk("stall.release_id", 68'(rsp_id), 68'(h_id));
    chk("stall.release_p", rsp_p, h_p);
    repeat (3) tick(100, 100);
    drain("stall");

    repeat (300) tick(60, 65);
    drain("rand");

    // Reset with two results in flight.
    rsp_ready = 1'b1;
    new_data(1);
    req_valid = 4'b0010;
    sync();
    new_data(1);
    sync();
    req_valid = '0;
    chk("midrst.inflight_before", 68'(inflight), 68'd2);
    ap_rst_n = 1'b0;
    #1;
    chk("midrst.rsp_valid", 68'(rsp_valid), 68'd0);
    chk("midrst.rsp_id", 68'(rsp_id), 68'd0);
    chk("midrst.rsp_p", rsp_p, 68'd0);
    chk("midrst.inflight", 68'(inflight), 68'd0);
    chk("midrst.idle", 68'(idle), 68'd1);
    sync();
    ap_rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge ap_clk);
      chk($sformatf("midrst.no_stale%0d", k), 68'(rsp_valid), 68'd0);
    end
    sync();
    single("midrst.after", 3, 32'hDEAD_BEEF, 36'h0_0000_0010, 68'hD_EADB_EEF0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
